// File: rtl/vadd_ctrl_regs.sv
// AXI4-Lite control/status register slave for the vector-add kernel.
// Define VADD_CTRL_IRQ_PULSE_EN to make usr_irq a one-cycle pulse instead of a level.
module vadd_ctrl_regs #(
    parameter int AXIL_ADDR_WIDTH = 16,
    parameter int AXIL_DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                         s_axil_awvalid,
    output logic                         s_axil_awready,
    input  logic [AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                         s_axil_wvalid,
    output logic                         s_axil_wready,
    output logic [1:0]                   s_axil_bresp,
    output logic                         s_axil_bvalid,
    input  logic                         s_axil_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                         s_axil_arvalid,
    output logic                         s_axil_arready,
    output logic [AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                   s_axil_rresp,
    output logic                         s_axil_rvalid,
    input  logic                         s_axil_rready,
    output logic [31:0]                  a_baseaddr,
    output logic [31:0]                  b_baseaddr,
    output logic [31:0]                  c_baseaddr,
    output logic [31:0]                  vector_len,
    output logic                         core_start,
    input  logic                         core_done,
    output logic                         usr_irq
);
    localparam logic [5:0] ADDR_START = 6'h00;
    localparam logic [5:0] ADDR_A     = 6'h01;
    localparam logic [5:0] ADDR_B     = 6'h02;
    localparam logic [5:0] ADDR_C     = 6'h03;
    localparam logic [5:0] ADDR_LEN   = 6'h04;
    localparam logic [5:0] ADDR_INT   = 6'h05;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic        r_live;
    logic        r_aw_held, r_w_held;
    logic [5:0]  r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_bvalid, r_rvalid;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata;
    logic [31:0] r_a_base, r_b_base, r_c_base, r_vlen;
    logic        r_busy, r_done_sticky, r_irq_pending, r_core_start, r_usr_irq;

    logic        w_aw_hs, w_w_hs, w_ar_hs, w_wr_fire;
    logic [5:0]  w_wr_addr;
    logic [31:0] w_wr_data, w_rd_mux;
    logic [3:0]  w_wr_strb;
    logic        w_start, w_start_ok, w_done_acc, w_irq_clr, w_irq_next;
    logic        w_unused;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] m;
        m = old_v;
        for (int i = 0; i < 4; i++)
            if (strb[i]) m[8*i +: 8] = new_v[8*i +: 8];
        return m;
    endfunction

    // Readies stay low through reset and come up on the first edge afterwards.
    assign s_axil_awready = r_live & ~r_aw_held & ~r_bvalid;
    assign s_axil_wready  = r_live & ~r_w_held & ~r_bvalid;
    assign s_axil_arready = r_live & ~r_rvalid;

    assign w_aw_hs = s_axil_awvalid & s_axil_awready;
    assign w_w_hs  = s_axil_wvalid & s_axil_wready;
    assign w_ar_hs = s_axil_arvalid & s_axil_arready;

    // A handshake this cycle counts as held so the write commits without an extra cycle.
    assign w_wr_fire = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_wr_addr = r_aw_held ? r_awaddr : s_axil_awaddr[7:2];
    assign w_wr_data = r_w_held ? r_wdata : s_axil_wdata;
    assign w_wr_strb = r_w_held ? r_wstrb : s_axil_wstrb;

    // busy is the pre-edge value, so a START coinciding with core_done is rejected.
    assign w_start    = w_wr_fire & (w_wr_addr == ADDR_START);
    assign w_start_ok = w_start & ~r_busy;
    assign w_done_acc = core_done & r_busy;
    assign w_irq_clr  = w_wr_fire & (w_wr_addr == ADDR_INT) & w_wr_strb[0] & w_wr_data[0];
    assign w_irq_next = w_done_acc | (r_irq_pending & ~w_irq_clr);

    assign w_unused = ^{s_axil_awaddr, s_axil_araddr};

    always_comb begin
        w_rd_mux = 32'h0;
        case (s_axil_araddr[7:2])
            ADDR_START: w_rd_mux = {30'h0, r_done_sticky, r_busy};
            ADDR_A:     w_rd_mux = r_a_base;
            ADDR_B:     w_rd_mux = r_b_base;
            ADDR_C:     w_rd_mux = r_c_base;
            ADDR_LEN:   w_rd_mux = r_vlen;
            ADDR_INT:   w_rd_mux = {31'h0, r_irq_pending};
            default:    w_rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live    <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= 6'h0;
            r_wdata   <= 32'h0;
            r_wstrb   <= 4'h0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= 32'h0;
        end else begin
            r_live <= 1'b1;
            if (w_wr_fire) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= (w_start & r_busy) ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= s_axil_awaddr[7:2];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= s_axil_wdata;
                    r_wstrb  <= s_axil_wstrb;
                end
                if (r_bvalid && s_axil_bready)
                    r_bvalid <= 1'b0;
            end
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
                r_rresp  <= RESP_OKAY;
            end else if (r_rvalid && s_axil_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_base      <= 32'h0;
            r_b_base      <= 32'h0;
            r_c_base      <= 32'h0;
            r_vlen        <= 32'h0;
            r_busy        <= 1'b0;
            r_done_sticky <= 1'b0;
            r_irq_pending <= 1'b0;
            r_core_start  <= 1'b0;
            r_usr_irq     <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                case (w_wr_addr)
                    ADDR_A:   r_a_base <= merge_bytes(r_a_base, w_wr_data, w_wr_strb);
                    ADDR_B:   r_b_base <= merge_bytes(r_b_base, w_wr_data, w_wr_strb);
                    ADDR_C:   r_c_base <= merge_bytes(r_c_base, w_wr_data, w_wr_strb);
                    ADDR_LEN: r_vlen   <= merge_bytes(r_vlen, w_wr_data, w_wr_strb);
                    default:  ;
                endcase
            end
            r_core_start <= w_start_ok;
            if (w_start_ok)
                r_busy <= 1'b1;
            else if (w_done_acc)
                r_busy <= 1'b0;
            // A completion in the same cycle as the clear wins, so no event is lost.
            if (w_done_acc)
                r_done_sticky <= 1'b1;
            else if (w_start_ok || w_irq_clr)
                r_done_sticky <= 1'b0;
            r_irq_pending <= w_irq_next;
`ifdef VADD_CTRL_IRQ_PULSE_EN
            r_usr_irq <= w_done_acc;
`else
            r_usr_irq <= w_irq_next;
`endif
        end
    end

    assign s_axil_bvalid = r_bvalid;
    assign s_axil_bresp  = r_bresp;
    assign s_axil_rvalid = r_rvalid;
    assign s_axil_rresp  = r_rresp;
    assign s_axil_rdata  = r_rdata;
    assign a_baseaddr    = r_a_base;
    assign b_baseaddr    = r_b_base;
    assign c_baseaddr    = r_c_base;
    assign vector_len    = r_vlen;
    assign core_start    = r_core_start;
    assign usr_irq       = r_usr_irq;

endmodule

// File: tb/tb_vadd_ctrl_regs.sv
// Directed bench for vadd_ctrl_regs: register table, channel ordering, START/done/irq flow.
// Honours VADD_CTRL_IRQ_PULSE_EN when the design is built with it.
module tb_vadd_ctrl_regs;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] awaddr = '0, araddr = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        core_done = 0;
    logic        awready, wready, bvalid, arready, rvalid, core_start, usr_irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, a_base, b_base, c_base, vlen;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int irq_cnt = 0;

`ifdef VADD_CTRL_IRQ_PULSE_EN
    localparam logic IRQ_HOLD = 1'b0;
`else
    localparam logic IRQ_HOLD = 1'b1;
`endif

    vadd_ctrl_regs #(.AXIL_ADDR_WIDTH(16), .AXIL_DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .a_baseaddr(a_base), .b_baseaddr(b_base), .c_baseaddr(c_base), .vector_len(vlen),
        .core_start(core_start), .core_done(core_done), .usr_irq(usr_irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (core_start) start_cnt++;
        if (usr_irq) irq_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_r;
    } vec_t;
    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic st);
        bit aw_ok, w_ok;
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1; wvalid = 1; bready = 1;
        aw_ok = 0; w_ok = 0; n = 0;
        resp = 2'bxx; st = 1'b0;
        while (!(aw_ok && w_ok) && n < 20) begin
            if (awvalid && awready) aw_ok = 1;
            if (wvalid && wready) w_ok = 1;
            tick();
            if (aw_ok) awvalid = 0;
            if (w_ok) wvalid = 0;
            n++;
        end
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        if (!bvalid) timeout("write_b");
        resp = bresp;
        st = core_start;
        tick();
    endtask

    task automatic axi_read(input logic [15:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        araddr = addr; arvalid = 1; rready = 1; n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        tick();
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        if (!rvalid) timeout("read_r");
        data = rdata;
        resp = rresp;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs, bs;
        logic        st;
        int          irq_before;

        vecs[0] = '{16'h0004, 32'h8000_0000, 4'hF, 32'h8000_0000};
        vecs[1] = '{16'h0008, 32'h8000_0100, 4'hF, 32'h8000_0100};
        vecs[2] = '{16'h000C, 32'h8000_0200, 4'hF, 32'h8000_0200};
        vecs[3] = '{16'h0010, 32'd64,        4'hF, 32'd64};
        vecs[4] = '{16'h0004, 32'h8000_0000, 4'h1, 32'h8000_0000};
        vecs[5] = '{16'h0008, 32'h1234_5678, 4'h1, 32'h8000_0178};
        vecs[6] = '{16'h0008, 32'h1234_5678, 4'hC, 32'h1234_0178};
        vecs[7] = '{16'h0018, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};

        // Reset
        repeat (10) tick();
        check("rst_awready", awready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_irq", usr_irq, 0);
        rst_n = 1;
        check("post_rst_arready_before_edge", arready, 0);
        tick();
        check("post_rst_readies", {29'b0, awready, wready, arready}, 32'h7);
        check("post_rst_start", core_start, 0);
        check("post_rst_vlen", vlen, 0);

        // Register table
        for (int i = 0; i < 8; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, bs, st);
            check($sformatf("vec%0d_bresp", i), bs, 2'b00);
            axi_read(vecs[i].addr, rd, rs);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_r);
            check($sformatf("vec%0d_rresp", i), rs, 2'b00);
        end
        check("out_a", a_base, 32'h8000_0000);
        check("out_b", b_base, 32'h1234_0178);
        check("out_c", c_base, 32'h8000_0200);
        check("out_len", vlen, 32'd64);

        // W leads AW by 3 cycles; bready held low
        bready = 0;
        wdata = 32'hAAAA_5555; wstrb = 4'hF; wvalid = 1;
        tick();
        wvalid = 0;
        check("wfirst_wready_held", wready, 0);
        tick(); tick();
        check("wfirst_no_b_yet", bvalid, 0);
        awaddr = 16'h000C; awvalid = 1;
        tick();
        awvalid = 0;
        check("wfirst_bvalid", bvalid, 1);
        check("wfirst_c_out", c_base, 32'hAAAA_5555);
        repeat (5) begin
            tick();
            check("bhold_bvalid", bvalid, 1);
            check("bhold_awready", awready, 0);
        end
        bready = 1;
        tick();
        check("bhold_release", bvalid, 0);

        // AW leads W by 3 cycles
        awaddr = 16'h0010; awvalid = 1;
        tick();
        awvalid = 0;
        check("awfirst_awready_held", awready, 0);
        tick(); tick();
        check("awfirst_no_b_yet", bvalid, 0);
        wdata = 32'h0000_0100; wstrb = 4'hF; wvalid = 1;
        tick();
        wvalid = 0;
        check("awfirst_bvalid", bvalid, 1);
        check("awfirst_len_out", vlen, 32'h100);
        tick();
        check("awfirst_release", bvalid, 0);

        // START while idle, then while busy
        axi_write(16'h0000, 32'h0, 4'hF, bs, st);
        check("start1_bresp", bs, 2'b00);
        check("start1_pulse_with_b", st, 1);
        tick();
        check("start1_pulse_count", start_cnt, 1);
        axi_read(16'h0000, rd, rs);
        check("status_busy", rd, 32'h1);
        axi_write(16'h0000, 32'h0, 4'hF, bs, st);
        check("start2_bresp", bs, 2'b10);
        check("start2_no_pulse", start_cnt, 1);

        // Completion
        irq_before = irq_cnt;
        core_done = 1;
        check("irq_before_done", usr_irq, 0);
        tick();
        core_done = 0;
        check("irq_rise", usr_irq, 1);
        tick();
        check("irq_after_1", usr_irq, IRQ_HOLD);
`ifdef VADD_CTRL_IRQ_PULSE_EN
        check("irq_pulse_width", irq_cnt - irq_before, 1);
`endif
        axi_read(16'h0000, rd, rs);
        check("status_done", rd, 32'h2);
        axi_read(16'h0014, rd, rs);
        check("int_pending", rd, 32'h1);

        // W1C
        axi_write(16'h0014, 32'h1, 4'hF, bs, st);
        check("w1c_bresp", bs, 2'b00);
        check("w1c_irq", usr_irq, 0);
        axi_read(16'h0000, rd, rs);
        check("status_cleared", rd, 32'h0);

        // core_done while idle
        irq_before = irq_cnt;
        core_done = 1;
        tick();
        core_done = 0;
        tick();
        check("idle_done_irq", usr_irq, 0);
        check("idle_done_irq_cnt", irq_cnt - irq_before, 0);
        axi_read(16'h0014, rd, rs);
        check("idle_done_pending", rd, 32'h0);

        // START completing together with core_done
        axi_write(16'h0000, 32'h0, 4'hF, bs, st);
        check("start3_bresp", bs, 2'b00);
        tick();
        check("start3_pulse_count", start_cnt, 2);
        awaddr = 16'h0000; wdata = 32'h0; wstrb = 4'hF; bready = 1;
        awvalid = 1; wvalid = 1; core_done = 1;
        check("collide_awready", awready, 1);
        tick();
        awvalid = 0; wvalid = 0; core_done = 0;
        check("collide_bvalid", bvalid, 1);
        check("collide_bresp", bresp, 2'b10);
        check("collide_irq", usr_irq, 1);
        tick();
        tick();
        check("collide_no_pulse", start_cnt, 2);
        axi_read(16'h0000, rd, rs);
        check("collide_status", rd, 32'h2);
        axi_read(16'h0018, rd, rs);
        check("unmapped_read", rd, 32'h0);
        check("unmapped_rresp", rs, 2'b00);

        // Reset mid-transaction drops the pending R response
        araddr = 16'h0010; arvalid = 1; rready = 0;
        tick();
        arvalid = 0;
        check("pending_rvalid", rvalid, 1);
        #2;
        rst_n = 0;
        #1;
        check("async_rst_rvalid", rvalid, 0);
        check("async_rst_len", vlen, 0);
        check("async_rst_irq", usr_irq, 0);
        check("async_rst_arready", arready, 0);
        tick();
        rst_n = 1;
        rready = 1;
        tick();
        check("rerst_arready", arready, 1);
        axi_read(16'h0000, rd, rs);
        check("rerst_status", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
